// File: rtl/fb_pkg.sv
// fb_pkg: shared frame-buffer state enum and frame geometry derivation.
package fb_pkg;
  typedef enum logic [1:0] {IDLE, SWAP_WAIT, CLEAR} fb_state_e;
  localparam int FB_COLS  = 64;
  localparam int FB_ROWS  = 32;
  localparam int FB_FRAME = FB_COLS * FB_ROWS;
  function automatic int fb_aw(input int frame);
    return (frame > 1) ? $clog2(frame) : 1;
  endfunction
  localparam int FB_AW = fb_aw(FB_FRAME);
endpackage

// File: rtl/fb_clear_sweeper.sv
// fb_clear_sweeper: walks addresses 0..FRAME-1, one per cycle, after a start pulse.
module fb_clear_sweeper #(
  parameter int FRAME = 2048,
  parameter int AW    = 11
) (
  input  logic          i_clk,
  input  logic          rst_n,
  input  logic          i_start,
  output logic [AW-1:0] o_addr,
  output logic          o_done
);
  localparam logic [AW-1:0] LAST = AW'(FRAME - 1);
  logic          r_busy;
  logic [AW-1:0] r_addr;
  assign o_addr = r_addr;
  assign o_done = r_busy && (r_addr == LAST);
  always_ff @(posedge i_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_busy <= 1'b0;
      r_addr <= '0;
    end else if (i_start) begin
      r_busy <= 1'b1;
      r_addr <= '0;
    end else if (o_done) begin
      r_busy <= 1'b0;
      r_addr <= '0;
    end else if (r_busy) begin
      r_addr <= r_addr + 1'b1;
    end
  end
endmodule

// File: rtl/fb_swap_arbiter.sv
// fb_swap_arbiter: LED frame double-buffer controller; banks swap only on scan frame end.
// FB_CLEAR_ON_SWAP_EN adds a zero-fill sweep of the new back bank after each swap.
module fb_swap_arbiter
  import fb_pkg::*;
#(
  parameter int MATRIX_COLS = FB_COLS,
  parameter int MATRIX_ROWS = FB_ROWS,
  parameter int PWM_BITS    = 1,
  localparam int PW    = 3 * PWM_BITS,
  localparam int FRAME = MATRIX_COLS * MATRIX_ROWS,
  localparam int AW    = fb_aw(FRAME)
) (
  input  logic          i_clk,
  input  logic          rst_n,
  input  logic [AW-1:0] i_scan_addr,
  output logic [PW-1:0] o_scan_data,
  input  logic          i_frame_end,
  input  logic          i_wr_valid,
  output logic          o_wr_ready,
  input  logic [AW-1:0] i_wr_addr,
  input  logic [PW-1:0] i_wr_data,
  input  logic          i_swap_req,
  output logic          o_swap_pending,
  output logic          o_swap_done,
  output logic          o_front_sel,
  output logic [AW:0]   o_ram_raddr,
  input  logic [PW-1:0] i_ram_rdata,
  output logic          o_ram_we,
  output logic [AW:0]   o_ram_waddr,
  output logic [PW-1:0] o_ram_wdata
);
  localparam logic [AW:0] FRAME_W = (AW + 1)'(FRAME);
  fb_state_e r_state;
  logic      r_front_sel, r_swap_pending, r_swap_done;
  logic      w_fire, w_in_range, w_swap;
  assign o_wr_ready     = (r_state == IDLE);
  assign o_front_sel    = r_front_sel;
  assign o_swap_pending = r_swap_pending;
  assign o_swap_done    = r_swap_done;
  assign o_ram_raddr    = {r_front_sel, i_scan_addr};
  assign o_scan_data    = i_ram_rdata;
  assign w_fire         = i_wr_valid && o_wr_ready;
  assign w_in_range     = {1'b0, i_wr_addr} < FRAME_W;
  assign w_swap         = (r_state == SWAP_WAIT) && i_frame_end;
`ifdef FB_CLEAR_ON_SWAP_EN
  localparam fb_state_e AFTER_SWAP = CLEAR;
  logic [AW-1:0] w_clr_addr;
  logic          w_clr_done, w_clr;
  fb_clear_sweeper #(.FRAME(FRAME), .AW(AW)) u_sweeper (
    .i_clk   (i_clk),
    .rst_n   (rst_n),
    .i_start (w_swap),
    .o_addr  (w_clr_addr),
    .o_done  (w_clr_done)
  );
  assign w_clr       = (r_state == CLEAR);
  assign o_ram_we    = w_clr || (w_fire && w_in_range);
  assign o_ram_waddr = {~r_front_sel, w_clr ? w_clr_addr : i_wr_addr};
  assign o_ram_wdata = w_clr ? '0 : i_wr_data;
`else
  localparam fb_state_e AFTER_SWAP = IDLE;
  assign o_ram_we    = w_fire && w_in_range;
  assign o_ram_waddr = {~r_front_sel, i_wr_addr};
  assign o_ram_wdata = i_wr_data;
`endif
  // A request sampled together with a frame end only arms the swap; it never swaps in the same cycle.
  always_ff @(posedge i_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state        <= IDLE;
      r_front_sel    <= 1'b0;
      r_swap_pending <= 1'b0;
      r_swap_done    <= 1'b0;
    end else begin
      r_swap_done <= w_swap;
      case (r_state)
        IDLE: if (i_swap_req) begin
          r_state        <= SWAP_WAIT;
          r_swap_pending <= 1'b1;
        end
        SWAP_WAIT: if (i_frame_end) begin
          r_state        <= AFTER_SWAP;
          r_swap_pending <= 1'b0;
          r_front_sel    <= ~r_front_sel;
        end
`ifdef FB_CLEAR_ON_SWAP_EN
        CLEAR: if (w_clr_done) r_state <= IDLE;
`endif
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_fb_swap_arbiter.sv
// tb_fb_swap_arbiter: directed + random checks of fb_swap_arbiter against a frame-level model.
// 24 rows makes FRAME non-power-of-two so out-of-range host addresses exist.
module tb_fb_swap_arbiter;
  localparam int COLS  = 64;
  localparam int ROWS  = 24;
  localparam int PW    = 3;
  localparam int FRAME = COLS * ROWS;
  localparam int AW    = $clog2(FRAME);

  logic clk = 1'b0, rst_n = 1'b0;
  logic [AW-1:0] scan_addr = '0, wr_addr = '0;
  logic [PW-1:0] wr_data = '0, ram_rdata = '0;
  logic frame_end = 1'b0, wr_valid = 1'b0, swap_req = 1'b0;
  logic [PW-1:0] o_scan_data, o_ram_wdata;
  logic o_wr_ready, o_swap_pending, o_swap_done, o_front_sel, o_ram_we;
  logic [AW:0] o_ram_raddr, o_ram_waddr;

  always #5 clk = ~clk;

  fb_swap_arbiter #(.MATRIX_COLS(COLS), .MATRIX_ROWS(ROWS), .PWM_BITS(1)) dut (
    .i_clk(clk), .rst_n(rst_n), .i_scan_addr(scan_addr), .o_scan_data(o_scan_data),
    .i_frame_end(frame_end), .i_wr_valid(wr_valid), .o_wr_ready(o_wr_ready),
    .i_wr_addr(wr_addr), .i_wr_data(wr_data), .i_swap_req(swap_req),
    .o_swap_pending(o_swap_pending), .o_swap_done(o_swap_done), .o_front_sel(o_front_sel),
    .o_ram_raddr(o_ram_raddr), .i_ram_rdata(ram_rdata), .o_ram_we(o_ram_we),
    .o_ram_waddr(o_ram_waddr), .o_ram_wdata(o_ram_wdata)
  );

  logic [PW-1:0] ram [2**(AW+1)] = '{default: '0};
  always @(posedge clk) begin
    if (o_ram_we) ram[o_ram_waddr] <= o_ram_wdata;
    ram_rdata <= ram[o_ram_raddr];
  end

  // Reference: two frames of pixels, which one is shown, and swap bookkeeping.
  logic [PW-1:0] m_mem [2][FRAME] = '{default: '0};
  logic m_front = 1'b0, m_pend = 1'b0, m_done = 1'b0, m_sv = 1'b0;
  logic [PW-1:0] m_scan = '0;
  int m_clr = 0;
  int checks = 0, errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_front = 1'b0; m_pend = 1'b0; m_done = 1'b0; m_clr = 0; m_sv = 1'b0;
  endtask

  task automatic step();
    logic rdy, ewe;
    logic [AW:0] ewa;
    logic [PW-1:0] ewd;
    #1;
    rdy = !m_pend && m_clr == 0;
    chk("ready", 32'(o_wr_ready), 32'(rdy));
    chk("front", 32'(o_front_sel), 32'(m_front));
    chk("pending", 32'(o_swap_pending), 32'(m_pend));
    chk("done", 32'(o_swap_done), 32'(m_done));
    chk("raddr", 32'(o_ram_raddr), 32'({m_front, scan_addr}));
    if (m_sv) chk("scan_data", 32'(o_scan_data), 32'(m_scan));
    if (m_clr > 0) begin
      ewe = 1'b1; ewa = {~m_front, AW'(FRAME - m_clr)}; ewd = '0;
    end else begin
      ewe = rdy && wr_valid && (int'(wr_addr) < FRAME); ewa = {~m_front, wr_addr}; ewd = wr_data;
    end
    chk("we", 32'(o_ram_we), 32'(ewe));
    if (ewe) begin
      chk("waddr", 32'(o_ram_waddr), 32'(ewa));
      chk("wdata", 32'(o_ram_wdata), 32'(ewd));
    end
    m_scan = m_mem[m_front][scan_addr];
    m_sv = 1'b1;
    @(posedge clk);
    m_done = 1'b0;
    if (m_clr > 0) begin
      m_mem[~m_front][FRAME - m_clr] = '0;
      m_clr--;
    end else if (m_pend) begin
      if (frame_end) begin
        m_front = ~m_front; m_done = 1'b1; m_pend = 1'b0;
`ifdef FB_CLEAR_ON_SWAP_EN
        m_clr = FRAME;
`endif
      end
    end else begin
      if (wr_valid && int'(wr_addr) < FRAME) m_mem[~m_front][wr_addr] = wr_data;
      if (swap_req) m_pend = 1'b1;
    end
    #1;
  endtask

  task automatic pulse_reset();
    rst_n = 1'b0;
    #1;
    chk("rst_ready", 32'(o_wr_ready), 32'd1);
    chk("rst_pending", 32'(o_swap_pending), 32'd0);
    chk("rst_front", 32'(o_front_sel), 32'd0);
    model_reset();
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  initial begin
    int cnt;
    scan_addr = AW'(5);
    #2;
    chk("reset_front", 32'(o_front_sel), 32'd0);
    chk("reset_ready", 32'(o_wr_ready), 32'd1);
    chk("reset_done", 32'(o_swap_done), 32'd0);
    chk("reset_we", 32'(o_ram_we), 32'd0);
    chk("reset_raddr", 32'(o_ram_raddr), 32'h005);
    @(posedge clk); #1;
    rst_n = 1'b1;
    step();
    // host write into back bank
    wr_valid = 1'b1; wr_addr = AW'(16); wr_data = 3'b101;
    #1;
    chk("wr_we", 32'(o_ram_we), 32'd1);
    chk("wr_waddr", 32'(o_ram_waddr), 32'h810);
    chk("wr_wdata", 32'(o_ram_wdata), 32'h5);
    step();
    // out-of-range write completes handshake without RAM write
    wr_addr = AW'(FRAME + 64);
    #1;
    chk("oor_ready", 32'(o_wr_ready), 32'd1);
    chk("oor_we", 32'(o_ram_we), 32'd0);
    step();
    wr_valid = 1'b0;
    // swap with a 100-cycle wait for frame end
    swap_req = 1'b1; step(); swap_req = 1'b0;
    for (int i = 0; i < 100; i++) begin
      chk("wait_pending", 32'(o_swap_pending), 32'd1);
      step();
    end
    frame_end = 1'b1; step(); frame_end = 1'b0;
    chk("swap_front", 32'(o_front_sel), 32'd1);
    chk("swap_done", 32'(o_swap_done), 32'd1);
    chk("swap_raddr_msb", 32'(o_ram_raddr[AW]), 32'd1);
    step();
    chk("swap_done_drop", 32'(o_swap_done), 32'd0);
    while (m_clr > 0) step();
`ifdef FB_CLEAR_ON_SWAP_EN
    cnt = 0;
    for (int i = 0; i < FRAME; i++) if (ram[{~m_front, AW'(i)}] != '0) cnt++;
    chk("clear_nonzero", 32'(cnt), 32'd0);
`endif
    // simultaneous request and frame end, plus a duplicate request while waiting
    swap_req = 1'b1; frame_end = 1'b1; step(); frame_end = 1'b0; swap_req = 1'b0;
    chk("simul_front", 32'(o_front_sel), 32'd1);
    chk("simul_pending", 32'(o_swap_pending), 32'd1);
    repeat (3) step();
    swap_req = 1'b1; step(); swap_req = 1'b0;
    repeat (3) step();
    frame_end = 1'b1; step(); frame_end = 1'b0;
    cnt = int'(o_swap_done);
    for (int i = 0; i < 8; i++) begin step(); cnt += int'(o_swap_done); end
    chk("one_swap", 32'(cnt), 32'd1);
    chk("one_swap_front", 32'(o_front_sel), 32'd0);
    while (m_clr > 0) step();
    // reset while a swap (and, if enabled, a clear) is in flight
    swap_req = 1'b1; step(); swap_req = 1'b0;
    step();
`ifdef FB_CLEAR_ON_SWAP_EN
    frame_end = 1'b1; step(); frame_end = 1'b0;
    repeat (50) step();
    chk("midclear_ready", 32'(o_wr_ready), 32'd0);
`endif
    pulse_reset();
    step();
    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      swap_req  = ($urandom_range(0, 19) == 0);
      frame_end = ($urandom_range(0, 39) == 0);
      wr_valid  = $urandom_range(0, 1) == 1;
      wr_addr   = AW'($urandom_range(0, 2**AW - 1));
      wr_data   = PW'($urandom);
      scan_addr = AW'($urandom_range(0, FRAME - 1));
      step();
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end
endmodule
